// File: rtl/line_queue_hub_pkg.sv
// Shared types and constants for the line queue hub, parser and solver.
package lqh_pkg;

   typedef enum logic [1:0] {
      PH_LOAD     = 2'd0,
      PH_SOLVE    = 2'd1,
      PH_TRANSMIT = 2'd2
   } phase_t;

   localparam int ERR_OVF = 0;
   localparam int ERR_UDF = 1;
   localparam int ERR_CH  = 2;

   localparam int LQH_DATA_W = 16;
   localparam int LQH_DEPTH  = 1024;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/line_queue_hub_if.sv
// Parser/solver-facing bus of the line queue hub; LQH_WATERMARK_EN adds hiwater.
interface line_queue_hub_if #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = lqh_pkg::LQH_DATA_W,
   parameter int DEPTH  = lqh_pkg::LQH_DEPTH
);
   import lqh_pkg::*;

   localparam int CH_W  = clog2_min1(NUM_CH);
   localparam int OCC_W = $clog2(DEPTH) + 1;

   logic                     parse_valid;
   logic [CH_W-1:0]          parse_ch;
   logic [DATA_W-1:0]        parse_data;
   logic                     parsed;
   logic [NUM_CH-1:0]        solve_wr;
   logic [NUM_CH*DATA_W-1:0] solve_wdata;
   logic [NUM_CH-1:0]        solve_rd;
   logic                     solved;
   logic                     assembled;
   logic [NUM_CH*DATA_W-1:0] rd_data;
   logic [NUM_CH-1:0]        empty;
   logic [NUM_CH-1:0]        full;
   logic [NUM_CH*OCC_W-1:0]  occupancy;
   logic                     all_empty;
   logic [1:0]               phase;
   logic [2:0]               err;
`ifdef LQH_WATERMARK_EN
   logic [NUM_CH*OCC_W-1:0]  hiwater;
`endif

   modport master (
      output parse_valid, parse_ch, parse_data, parsed,
      output solve_wr, solve_wdata, solve_rd, solved, assembled,
`ifdef LQH_WATERMARK_EN
      input  hiwater,
`endif
      input  rd_data, empty, full, occupancy, all_empty, phase, err
   );

   modport slave (
      input  parse_valid, parse_ch, parse_data, parsed,
      input  solve_wr, solve_wdata, solve_rd, solved, assembled,
`ifdef LQH_WATERMARK_EN
      output hiwater,
`endif
      output rd_data, empty, full, occupancy, all_empty, phase, err
   );

endinterface

// File: rtl/line_queue_hub_sync_fifo.sv
// Single synchronous FIFO with flush, standard read timing; LQH_WATERMARK_EN adds peak occupancy.
module lqh_sync_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 1024,
   localparam int AW    = $clog2(DEPTH),
   localparam int OCC_W = AW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              wr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              rd_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              empty_o,
   output logic              full_o,
   output logic [OCC_W-1:0]  occ_o,
`ifdef LQH_WATERMARK_EN
   output logic [OCC_W-1:0]  hiwater_o,
`endif
   output logic              ovf_o,
   output logic              udf_o
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [DATA_W-1:0] rdata_q;
   logic              rd_ok, wr_ok, full_w, empty_w;

   assign empty_w = (occ_q == '0);
   assign full_w  = (occ_q == OCC_W'(DEPTH));
   assign rd_ok   = rd_i && !empty_w;
   // A full queue still takes a write when the same-cycle read frees a slot.
   assign wr_ok   = wr_i && (!full_w || rd_ok);

   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      occ_d = occ_q;
      if (flush_i) begin
         wp_d  = '0;
         rp_d  = '0;
         occ_d = '0;
      end else begin
         if (wr_ok) wp_d = wp_q + 1'b1;
         if (rd_ok) rp_d = rp_q + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok && !flush_i) mem[wp_q] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp_q    <= '0;
         rp_q    <= '0;
         occ_q   <= '0;
         rdata_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         occ_q <= occ_d;
         if (rd_ok && !flush_i) rdata_q <= mem[rp_q];
      end
   end

`ifdef LQH_WATERMARK_EN
   logic [OCC_W-1:0] hw_q;
   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) hw_q <= '0;
      else if (occ_d > hw_q) hw_q <= occ_d;
   end
   assign hiwater_o = hw_q;
`endif

   assign rdata_o = rdata_q;
   assign empty_o = empty_w;
   assign full_o  = full_w;
   assign occ_o   = occ_q;
   assign ovf_o   = wr_i && !wr_ok && !flush_i;
   assign udf_o   = rd_i && !rd_ok && !flush_i;

endmodule

// File: rtl/line_queue_hub.sv
// Phase sequencer, write-source mux and sticky errors over NUM_CH line queues.
// Optional LQH_WATERMARK_EN exposes per-channel peak occupancy on the bus.
module line_queue_hub
   import lqh_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int DATA_W = LQH_DATA_W,
   parameter int DEPTH  = LQH_DEPTH,
   localparam int CH_W  = clog2_min1(NUM_CH),
   localparam int OCC_W = $clog2(DEPTH) + 1
) (
   input logic              clk,
   input logic              rst_n,
   line_queue_hub_if.slave  bus
);

   phase_t                         phase_q;
   logic [2:0]                     err_q;
   logic [NUM_CH-1:0]              wr_req, ovf, udf, empty_w;
   logic [NUM_CH-1:0][DATA_W-1:0]  wdata;
   logic                           in_load, in_solve, bad_ch, flush;

   assign in_load  = (phase_q == PH_LOAD);
   assign in_solve = (phase_q == PH_SOLVE);
   assign bad_ch   = in_load && bus.parse_valid && (int'(bus.parse_ch) >= NUM_CH);
   assign flush    = in_solve && bus.solved;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign wr_req[k] = (in_load && bus.parse_valid && (int'(bus.parse_ch) == k)) ||
                         (in_solve && bus.solve_wr[k]);
      assign wdata[k]  = in_load ? bus.parse_data : bus.solve_wdata[k*DATA_W +: DATA_W];

      lqh_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush_i   (flush),
         .wr_i      (wr_req[k]),
         .wdata_i   (wdata[k]),
         .rd_i      (bus.solve_rd[k]),
         .rdata_o   (bus.rd_data[k*DATA_W +: DATA_W]),
         .empty_o   (empty_w[k]),
         .full_o    (bus.full[k]),
         .occ_o     (bus.occupancy[k*OCC_W +: OCC_W]),
`ifdef LQH_WATERMARK_EN
         .hiwater_o (bus.hiwater[k*OCC_W +: OCC_W]),
`endif
         .ovf_o     (ovf[k]),
         .udf_o     (udf[k])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_q <= PH_LOAD;
         err_q   <= '0;
      end else begin
         case (phase_q)
            PH_LOAD:     if (bus.parsed)    phase_q <= PH_SOLVE;
            PH_SOLVE:    if (bus.solved)    phase_q <= PH_TRANSMIT;
            PH_TRANSMIT: if (bus.assembled) phase_q <= PH_LOAD;
            default:                        phase_q <= PH_LOAD;
         endcase
         err_q[ERR_OVF] <= err_q[ERR_OVF] | (|ovf);
         err_q[ERR_UDF] <= err_q[ERR_UDF] | (|udf);
         err_q[ERR_CH]  <= err_q[ERR_CH]  | bad_ch;
      end
   end

   assign bus.empty     = empty_w;
   assign bus.all_empty = &empty_w;
   assign bus.phase     = phase_q;
   assign bus.err       = err_q;

endmodule
